// File: rtl/codedisk_sig_gen.sv
// Code-disk signal generator: emits a tooth waveform with a missing-tooth index slot,
// optional low glitches inside a chosen slot, and a once-per-revolution pulse.
module codedisk_sig_gen #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int TOOTH_NUM     = 100,
    parameter int MOTOR_FREQ    = 71,
    parameter int GLITCH_LEN    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [19:0] i_tooth_period,
    input  logic        i_glitch_en,
    input  logic [6:0]  i_glitch_slot,
    output logic        o_code_sig,
    output logic [6:0]  o_tooth_idx,
    output logic        o_rev_pulse,
    output logic        o_busy
);

    localparam int          DEF_PERIOD = 1_000_000_000 / (CLK_PERIOD_NS * MOTOR_FREQ * TOOTH_NUM);
    localparam logic [19:0] DEF_P      = 20'(DEF_PERIOD);
    localparam logic [6:0]  LAST_SLOT  = 7'(TOOTH_NUM - 1);
    localparam logic [19:0] GLEN       = 20'(GLITCH_LEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    logic [1:0]  state, state_n;
    logic [19:0] phase, phase_n;
    logic [19:0] period, period_n;
    logic [6:0]  slot, slot_n;
    logic        glitch, glitch_n;
    logic        slot_start;

    logic [19:0] eff_period;
    logic [19:0] hi_len;
    logic [19:0] lo_len;
    logic [19:0] g_start;
    logic [6:0]  slot_inc;
    logic        glitch_hit;
    logic        code_n;

    // Zero selects the default rate; tiny periods clamp so both phases are at least 2 clocks.
    always_comb begin
        eff_period = i_tooth_period;
        if (i_tooth_period == 20'd0) begin
            eff_period = DEF_P;
        end else if (i_tooth_period < 20'd4) begin
            eff_period = 20'd4;
        end
    end

    assign hi_len   = period >> 1;
    assign lo_len   = period - hi_len;
    assign slot_inc = (slot == LAST_SLOT) ? 7'd0 : slot + 7'd1;

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        period_n   = period;
        slot_n     = slot;
        glitch_n   = glitch;
        slot_start = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    slot_start = 1'b1;
                    slot_n     = 7'd0;
                end
            end
            HIGH: begin
                if (phase == hi_len - 20'd1) begin
                    state_n = LOW;
                    phase_n = 20'd0;
                end else begin
                    phase_n = phase + 20'd1;
                end
            end
            LOW: begin
                if (phase == lo_len - 20'd1) begin
                    if (i_enable) begin
                        slot_start = 1'b1;
                        slot_n     = slot_inc;
                    end else begin
                        state_n = IDLE;
                        phase_n = 20'd0;
                    end
                end else begin
                    phase_n = phase + 20'd1;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = 20'd0;
            end
        endcase
        // Period and glitch selection are only taken at slot starts.
        if (slot_start) begin
            state_n  = HIGH;
            phase_n  = 20'd0;
            period_n = eff_period;
            glitch_n = i_glitch_en && (i_glitch_slot == slot_n) && (i_glitch_slot < LAST_SLOT);
        end
    end

    assign g_start    = period_n >> 2;
    assign glitch_hit = glitch_n && (phase_n >= g_start) && (phase_n < g_start + GLEN);
    assign code_n     = (state_n == HIGH) && (slot_n != LAST_SLOT) && !glitch_hit;

    // Outputs are registered from the next-state values so they line up with the new state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            phase       <= 20'd0;
            period      <= 20'd0;
            slot        <= 7'd0;
            glitch      <= 1'b0;
            o_code_sig  <= 1'b0;
            o_tooth_idx <= 7'd0;
            o_rev_pulse <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            period      <= period_n;
            slot        <= slot_n;
            glitch      <= glitch_n;
            o_code_sig  <= code_n;
            o_tooth_idx <= slot_n;
            o_rev_pulse <= slot_start && (slot_n == 7'd0);
            o_busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_codedisk_sig_gen.sv
// Bench for codedisk_sig_gen: slot-level reference model checked every cycle,
// plus directed measurements of waveform features against hand-computed values.
module tb_codedisk_sig_gen;

    localparam int TOOTH_NUM  = 100;
    localparam int GLITCH_LEN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] tooth_period = 20'd0;
    logic        glitch_en = 1'b0;
    logic [6:0]  glitch_slot = 7'd0;
    logic        code_sig;
    logic [6:0]  tooth_idx;
    logic        rev_pulse;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    codedisk_sig_gen dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_tooth_period (tooth_period),
        .i_glitch_en    (glitch_en),
        .i_glitch_slot  (glitch_slot),
        .o_code_sig     (code_sig),
        .o_tooth_idx    (tooth_idx),
        .o_rev_pulse    (rev_pulse),
        .o_busy         (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: tracks which slot is running and how far into it we are.
    logic [9:0] exp_q[$];
    int  m_run  = 0;
    int  m_slot = 0;
    int  m_off  = 0;
    int  m_p    = 0;
    bit  m_glitch = 1'b0;
    bit  m_rev    = 1'b0;

    function automatic int eff(input logic [19:0] p);
        if (p == 20'd0) return 14084;
        if (p < 20'd4) return 4;
        return int'(p);
    endfunction

    task automatic model_new_slot(input int s);
        m_slot   = s;
        m_off    = 0;
        m_p      = eff(tooth_period);
        m_glitch = glitch_en && (int'(glitch_slot) == s) && (s < TOOTH_NUM - 1);
        m_rev    = (s == 0);
    endtask

    function automatic logic [9:0] model_out();
        bit code;
        code = (m_run != 0) && (m_off < m_p / 2) && (m_slot != TOOTH_NUM - 1)
               && !(m_glitch && (m_off >= m_p / 4) && (m_off < m_p / 4 + GLITCH_LEN));
        return {code, 7'(m_slot), m_rev, (m_run != 0)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_slot = 0; m_off = 0; m_p = 0; m_glitch = 1'b0; m_rev = 1'b0;
            exp_q.delete();
        end else begin
            m_rev = 1'b0;
            if (m_run == 0) begin
                if (enable) begin
                    m_run = 1;
                    model_new_slot(0);
                end
            end else if (m_off == m_p - 1) begin
                if (!enable) m_run = 0;
                else model_new_slot((m_slot + 1) % TOOTH_NUM);
            end else begin
                m_off++;
            end
            exp_q.push_back(model_out());
        end
    end

    // Scoreboard compare, one check per clock while out of reset
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL model_cmp t=%0t expected queue empty", $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({code_sig, tooth_idx, rev_pulse, busy} === e) n_pass++;
                    else $display("FAIL model_cmp t=%0t got code=%b idx=%0d rev=%b busy=%b exp code=%b idx=%0d rev=%b busy=%b",
                                  $time, code_sig, tooth_idx, rev_pulse, busy, e[9], e[8:2], e[1], e[0]);
                end
            end
        end
    end

    // Driver / helper tasks
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int target, input int budget);
        int prev;
        bit ok;
        ok = 1'b0;
        prev = int'(tooth_idx);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (int'(tooth_idx) == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = int'(tooth_idx);
        end
        chk($sformatf("wait_idx_%0d", target), int'(ok), 1);
    endtask

    // Starts on the first cycle of a slot, ends on the first cycle of the next one.
    task automatic measure_slot(input int chg_off, input logic [19:0] chg_val,
                                output int len, output int hi);
        int s;
        bit done;
        done = 1'b0;
        len = 1;
        hi = int'(code_sig);
        s = int'(tooth_idx);
        for (int k = 0; k < 20000; k++) begin
            if (k == chg_off) tooth_period = chg_val;
            tick();
            if (int'(tooth_idx) != s || !busy) begin
                done = 1'b1;
                break;
            end
            len++;
            hi += int'(code_sig);
        end
        chk("measure_slot_end", int'(done), 1);
    endtask

    initial begin
        int cnt, rises, low_run, max_low, prev_idx, len, hi;
        bit prev, ok;
        logic [9:0] pat;

        // Reset
        repeat (3) tick();
        chk("reset_code", int'(code_sig), 0);
        chk("reset_idx", int'(tooth_idx), 0);
        chk("reset_rev", int'(rev_pulse), 0);
        chk("reset_busy", int'(busy), 0);
        #2 rst = 1'b0;
        repeat (4) tick();
        chk("idle_busy", int'(busy), 0);

        // Two revolutions at P=20
        tooth_period = 20'd20;
        enable = 1'b1;
        tick();
        chk("start_rev", int'(rev_pulse), 1);
        chk("start_busy", int'(busy), 1);
        cnt = 0; rises = 0; low_run = 0; max_low = 0;
        prev = code_sig; prev_idx = int'(tooth_idx);
        ok = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            prev_idx = int'(tooth_idx);
            tick();
            cnt++;
            if (code_sig && !prev) rises++;
            if (!code_sig) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
            prev = code_sig;
            if (rev_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rev_seen", int'(ok), 1);
        chk("rev_period", cnt, 2000);
        chk("pulses_per_rev", rises, 99);
        chk("index_gap", max_low, 30);
        chk("idx_before_wrap", prev_idx, 99);
        chk("idx_after_wrap", int'(tooth_idx), 0);

        // Period change mid slot 5, then clamp
        wait_idx(5, 200);
        measure_slot(3, 20'd40, len, hi);
        chk("slot5_len", len, 20);
        measure_slot(-1, 20'd0, len, hi);
        chk("slot6_len", len, 40);
        chk("slot6_high", hi, 20);
        measure_slot(2, 20'd1, len, hi);
        chk("slot7_len", len, 40);
        measure_slot(-1, 20'd0, len, hi);
        chk("clamp_len", len, 4);
        chk("clamp_high", hi, 2);

        // Glitch in slot 3
        tooth_period = 20'd20;
        glitch_en = 1'b1;
        glitch_slot = 7'd3;
        wait_idx(3, 5000);
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            pat = {pat[8:0], code_sig};
            tick();
        end
        chk("glitch_pattern", int'(pat), 999);
        repeat (10) tick();
        chk("glitch_slot_len", int'(tooth_idx), 4);
        measure_slot(-1, 20'd0, len, hi);
        chk("slot4_clean_high", hi, 10);

        // Disable mid slot 7
        glitch_en = 1'b0;
        glitch_slot = 7'd99;
        wait_idx(7, 200);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 5) enable = 1'b0;
            tick();
            cnt++;
            if (!busy) break;
        end
        chk("disable_slot_len", cnt, 20);
        chk("disable_code", int'(code_sig), 0);
        chk("disable_idx", int'(tooth_idx), 7);
        repeat (5) tick();
        chk("idle_idx_hold", int'(tooth_idx), 7);
        enable = 1'b1;
        tick();
        chk("reenable_rev", int'(rev_pulse), 1);
        chk("reenable_idx", int'(tooth_idx), 0);

        // Asynchronous reset during a HIGH phase
        tick();
        chk("pre_reset_high", int'(code_sig), 1);
        #3 rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_code", int'(code_sig), 0);
        chk("async_idx", int'(tooth_idx), 0);
        chk("async_busy", int'(busy), 0);
        repeat (2) tick();
        #2 rst = 1'b0;
        repeat (5) tick();
        chk("post_reset_idle", int'(busy), 0);

        // Default period
        tooth_period = 20'd0;
        enable = 1'b1;
        tick();
        chk("def_rev", int'(rev_pulse), 1);
        measure_slot(-1, 20'd0, len, hi);
        chk("def_slot_len", len, 14084);
        chk("def_slot_high", hi, 7042);
        enable = 1'b0;
        #2 rst = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b0;

        // Randomized run
        tooth_period = 20'(12);
        enable = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) tooth_period = 20'($urandom_range(1, 12));
            if (r == 5) enable = !enable;
            if (r == 7) glitch_en = 1'($urandom_range(0, 1));
            if (r == 8) glitch_slot = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(95, 127))
                                                                  : 7'($urandom_range(0, 5));
            if (k > 4900) enable = 1'b1;
            tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/codedisk_sig_gen.md
Name: codedisk_sig_gen

Overview:
- Synthesizable code-disk signal generator: the transmit side of the encoder input path. It drives a tooth waveform equivalent to the optical code-disk sensor output, including the missing-tooth index slot.
- Used in place of the physical sensor for bench and in-system self-test. Its output feeds the opto dejitter stage and then encoder angle computation.
- Optional glitch injection exercises the dejitter filter.

Parameters:
CLK_PERIOD_NS, 10, system clock period in ns
TOOTH_NUM, 100, slots per revolution; the last slot (TOOTH_NUM-1) is the index (missing tooth)
MOTOR_FREQ, 71, default revolutions per second
DEF_PERIOD, 1_000_000_000/(CLK_PERIOD_NS*MOTOR_FREQ*TOOTH_NUM) = 14084, default slot period in clocks
GLITCH_LEN, 2, injected low-glitch width in clocks

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_enable  in  1  run request
i_tooth_period  in  20  slot period in clocks; 0 selects DEF_PERIOD; values 1..3 clamp to 4
i_glitch_en  in  1  enable glitch injection
i_glitch_slot  in  7  slot index that receives the glitch
o_code_sig  out  1  generated code-disk signal
o_tooth_idx  out  7  current slot index, 0..TOOTH_NUM-1
o_rev_pulse  out  1  1-cycle pulse at the first clock of slot 0
o_busy  out  1  high while the generator is running

Behaviour:
- Reset values: o_code_sig=0, o_tooth_idx=0, o_rev_pulse=0, o_busy=0, state=IDLE, all counters 0.
- All outputs are registered.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - o_busy=0, o_code_sig=0.
  - On i_enable=1, latch the effective period P (after the 0/clamp rule), set slot=0, go to HIGH on the next clock.
  - o_rev_pulse=1 and o_busy=1 in that first HIGH cycle.
- Slot timing:
  - Each slot is exactly P clocks: HIGH phase of floor(P/2) clocks, then LOW phase of P-floor(P/2) clocks.
  - A phase counter counts 0..len-1 and the state advances when it reaches len-1.
- Index slot (slot==TOOTH_NUM-1): the HIGH phase drives o_code_sig=0 (missing tooth). The whole slot is low for P clocks, so the visible low gap is 2P - floor(P/2).
- Slot boundary (last LOW cycle):
  - slot wraps TOOTH_NUM-1 -> 0, otherwise increments.
  - o_tooth_idx updates on the first cycle of the new slot.
  - o_rev_pulse asserts on the first cycle of slot 0.
- Period change: i_tooth_period is sampled only at slot boundaries. A mid-slot change never alters the current slot length.
- Disable:
  - If i_enable falls, the current slot completes.
  - At the slot boundary the FSM goes to IDLE instead of starting the next slot; o_code_sig=0, o_busy=0.
  - o_tooth_idx holds its last value until the next enable, which restarts at slot 0.
- Glitch injection:
  - When i_glitch_en=1 at the slot boundary and the new slot == i_glitch_slot (and that slot is not the index slot), o_code_sig is forced low for GLITCH_LEN clocks.
  - The glitch starts at HIGH-phase offset floor(P/4).
  - Slot timing is unchanged.
  - If i_glitch_slot >= TOOTH_NUM-1, no glitch occurs.
- Simultaneous events:
  - Enable re-asserted in the same cycle that IDLE is entered: the FSM stays in IDLE for one cycle, then restarts.
  - Period change and disable at the same boundary: disable wins.
- Reset mid-operation forces reset values immediately (asynchronous), with no completion of the current slot.
- Width rules: the phase counter is 20 bits. P/2 and P/4 are right shifts. The clamp guarantees HIGH >= 2 and LOW >= 2 clocks.

Test Plan:
- Reset and enable, i_tooth_period=20, run 2 revolutions (TOOTH_NUM=100):
  - HIGH=10, LOW=10 per slot; 99 pulses per revolution.
  - Index low gap = 30 clocks.
  - o_rev_pulse every 2000 clocks; o_tooth_idx 0..99 wraps to 0.
- i_tooth_period=0:
  - Slot length = 14084 clocks (HIGH 7042).
  - Revolution = 1_408_400 clocks (≈71 Hz at 10 ns).
- i_tooth_period changed 20->40 at mid-slot 5:
  - Slot 5 stays 20 clocks; slot 6 is 40 clocks (HIGH 20).
  - i_tooth_period=1 → clamp: slots of 4 clocks (2/2).
- i_glitch_en=1, i_glitch_slot=3, P=20:
  - Slot 3 HIGH phase reads 1,1,1,1,1,0,0,1,1,1 (low at offsets 5-6); all other slots clean.
  - i_glitch_slot=99 → no glitch.
- Deassert i_enable in mid slot 7 (P=20):
  - Slot 7 completes its full 20 clocks, then o_busy=0 and o_code_sig=0; o_tooth_idx holds 7.
  - Re-enable restarts at slot 0 with o_rev_pulse.
- Assert i_rst during a HIGH phase: all outputs 0 within the same cycle (asynchronous); after release the generator stays IDLE until i_enable.
